// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// Decode/issue stage in front of the ALU. Each cycle it decodes one 32-bit
// instruction, reads the register file through two combinational read
// ports, and loads the ID/EX register with the ALU op, the operands and the
// writeback/memory controls. It also resolves BEQ/BNE one cycle later using
// the ALU zero flag, inserts a one-cycle bubble on a load-use hazard, and
// reports JMP redirects.
//
// Handshake: fetch holds in_valid/in_instr/in_pc. An instruction is consumed
// in any cycle where in_valid && in_ready. in_ready is low only during a
// load-use stall. A consumed instruction is either issued into ID/EX or,
// when br_taken is high, dropped (squashed).
//
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid/in_instr/in_pc/in_ready   fetch interface
//   rs_addr/rt_addr      regfile read addresses (combinational)
//   rs_data/rt_data      regfile read data (same cycle)
//   ex_*                 ID/EX register contents presented to the ALU/MEM/WB
//   alu_zero             ALU zero flag for the instruction held in ID/EX
//   br_taken/br_target   branch redirect (combinational) and target (registered)
//   jmp_taken/jmp_target JMP redirect for the instruction in decode
//   illegal              sticky illegal-opcode flag
//   stall_cnt            saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int DSIZE = 16,
  parameter int PCW   = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  input  logic [PCW-1:0]   in_pc,
  output logic             in_ready,
  output logic [AW-1:0]    rs_addr,
  output logic [AW-1:0]    rt_addr,
  input  logic [DSIZE-1:0] rs_data,
  input  logic [DSIZE-1:0] rt_data,
  output logic             ex_valid,
  output logic [2:0]       ex_op,
  output logic [DSIZE-1:0] ex_a,
  output logic [DSIZE-1:0] ex_b,
  output logic             ex_wr_en,
  output logic [AW-1:0]    ex_wr_addr,
  output logic             ex_mem_rd,
  output logic             ex_mem_wr,
  output logic [DSIZE-1:0] ex_store_data,
  input  logic             alu_zero,
  output logic             br_taken,
  output logic [PCW-1:0]   br_target,
  output logic             jmp_taken,
  output logic [PCW-1:0]   jmp_target,
  output logic             illegal,
  output logic [15:0]      stall_cnt
);

  // Opcode map (instr[31:28]); 0-7 are R-type with ALU op = opc[2:0].
  localparam logic [3:0] OPC_ADDI = 4'd8;
  localparam logic [3:0] OPC_LW   = 4'd9;
  localparam logic [3:0] OPC_SW   = 4'd10;
  localparam logic [3:0] OPC_BEQ  = 4'd11;
  localparam logic [3:0] OPC_BNE  = 4'd12;
  localparam logic [3:0] OPC_JMP  = 4'd13;
  localparam logic [3:0] OPC_ILL  = 4'd14;

  // ALU op encodings used outside the R-type range.
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;

  // Sign-extend or truncate a 16-bit immediate to DSIZE / PCW bits.
  function automatic logic [DSIZE-1:0] sext_d(input logic [15:0] v);
    logic [DSIZE-1:0] r;
    for (int i = 0; i < DSIZE; i++) r[i] = v[(i < 16) ? i : 15];
    return r;
  endfunction

  function automatic logic [PCW-1:0] sext_pc(input logic [15:0] v);
    logic [PCW-1:0] r;
    for (int i = 0; i < PCW; i++) r[i] = v[(i < 16) ? i : 15];
    return r;
  endfunction

  // Instruction fields
  logic [3:0]  opc;
  logic [3:0]  rd;
  logic [3:0]  rs;
  logic [3:0]  rt;
  logic [15:0] imm;

  assign opc = in_instr[31:28];
  assign rd  = in_instr[27:24];
  assign rs  = in_instr[23:20];
  assign rt  = in_instr[19:16];
  assign imm = in_instr[15:0];

  assign rs_addr    = AW'(rs);
  assign rt_addr    = AW'(rt);
  assign jmp_target = PCW'(imm);

  // Decoded controls for the instruction currently in decode
  logic             dec_valid;   // produces a real ID/EX entry
  logic [2:0]       dec_op;
  logic [DSIZE-1:0] dec_b;
  logic             dec_wr;
  logic             dec_mem_rd;
  logic             dec_mem_wr;
  logic             dec_beq;
  logic             dec_bne;
  logic             dec_jmp;
  logic             dec_ill;
  logic             dec_uses_rt;

  always_comb begin
    dec_valid   = 1'b0;
    dec_op      = ALU_ADD;
    dec_b       = sext_d(imm);
    dec_wr      = 1'b0;
    dec_mem_rd  = 1'b0;
    dec_mem_wr  = 1'b0;
    dec_beq     = 1'b0;
    dec_bne     = 1'b0;
    dec_jmp     = 1'b0;
    dec_ill     = 1'b0;
    dec_uses_rt = 1'b0;
    if (!opc[3]) begin
      // R-type: the full rt value is operand b (also the shift amount).
      dec_valid   = 1'b1;
      dec_op      = opc[2:0];
      dec_b       = rt_data;
      dec_wr      = 1'b1;
      dec_uses_rt = 1'b1;
    end else begin
      case (opc)
        OPC_ADDI: begin
          dec_valid = 1'b1;
          dec_wr    = 1'b1;
        end
        OPC_LW: begin
          dec_valid  = 1'b1;
          dec_wr     = 1'b1;
          dec_mem_rd = 1'b1;
        end
        OPC_SW: begin
          dec_valid   = 1'b1;
          dec_mem_wr  = 1'b1;
          dec_uses_rt = 1'b1;
        end
        OPC_BEQ, OPC_BNE: begin
          dec_valid   = 1'b1;
          dec_op      = ALU_SUB;
          dec_b       = rt_data;
          dec_beq     = (opc == OPC_BEQ);
          dec_bne     = (opc == OPC_BNE);
          dec_uses_rt = 1'b1;
        end
        // JMP redirects fetch directly and needs no ALU slot.
        OPC_JMP: dec_jmp = 1'b1;
        // Illegal behaves as a NOP apart from the sticky flag.
        OPC_ILL: dec_ill = 1'b1;
        default: ;
      endcase
    end
  end

  // ID/EX side-band state used for branch resolution
  logic ex_beq;
  logic ex_bne;

  logic load_use;
  logic stall;
  logic issue;

  assign br_taken = ex_valid && ((ex_beq && alu_zero) || (ex_bne && !alu_zero));

  assign load_use = ex_valid && ex_mem_rd && (ex_wr_addr != '0) && in_valid &&
                    ((ex_wr_addr == AW'(rs)) || (dec_uses_rt && (ex_wr_addr == AW'(rt))));

  // A taken branch squashes the decode slot, which overrides any stall.
  assign stall     = load_use && !br_taken;
  assign in_ready  = !stall;
  assign issue     = in_valid && !stall && !br_taken;
  assign jmp_taken = issue && dec_jmp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_op         <= '0;
      ex_a          <= '0;
      ex_b          <= '0;
      ex_wr_en      <= 1'b0;
      ex_wr_addr    <= '0;
      ex_mem_rd     <= 1'b0;
      ex_mem_wr     <= 1'b0;
      ex_store_data <= '0;
      ex_beq        <= 1'b0;
      ex_bne        <= 1'b0;
      br_target     <= '0;
      illegal       <= 1'b0;
      stall_cnt     <= '0;
    end else begin
      // Data fields load every cycle; they are meaningless in a bubble
      // because every control bit below is gated by the issue decision.
      ex_op         <= dec_op;
      ex_a          <= rs_data;
      ex_b          <= dec_b;
      ex_wr_addr    <= AW'(rd);
      ex_store_data <= rt_data;

      ex_valid  <= issue && dec_valid;
      ex_wr_en  <= issue && dec_wr && (rd != 4'd0);
      ex_mem_rd <= issue && dec_mem_rd;
      ex_mem_wr <= issue && dec_mem_wr;
      ex_beq    <= issue && dec_beq;
      ex_bne    <= issue && dec_bne;

      if (issue && (dec_beq || dec_bne))
        br_target <= in_pc + PCW'(1) + sext_pc(imm);

      if (issue && dec_ill)
        illegal <= 1'b1;

      if (stall && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule
